bmp180_word_collector: RTL

Downstream consumer of the BMP180 sensor controller's received-byte stream. It watches the per-byte `received` strobe and the 8-bit data bus and groups bytes into frames. It assembles each frame MSB-first into the chip ID, the eleven 16-bit calibration coefficients, raw temperature (UT) or raw pressure (UP), and commits them atomically to holding registers. Its outputs are the source for the future compensation stage and the display path.

---
 rtl/bmp180_word_collector.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/bmp180_word_collector.sv
// Groups the BMP180 received-byte stream into ID / calibration / UT / UP frames
// and commits each completed frame atomically to holding registers.
module bmp180_word_collector #(
  parameter int unsigned CALIB_WORDS = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frameStart,
  input  logic [1:0]  frameSel,
  input  logic        received,
  input  logic [7:0]  datareceive,
  input  logic [3:0]  rdAddr,
  output logic [15:0] rdData,
  output logic [7:0]  id,
  output logic [15:0] ut,
  output logic [23:0] up,
  output logic        idValid,
  output logic        calibValid,
  output logic        utValid,
  output logic        upValid,
  output logic        busy,
  output logic        frameDone,
  output logic        frameErr
);

  localparam int unsigned STAGE_BYTES = 2 * CALIB_WORDS;
  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_COLLECT  = 1'b1;
  localparam logic [1:0]  SEL_ID      = 2'd0;
  localparam logic [1:0]  SEL_CAL     = 2'd1;
  localparam logic [1:0]  SEL_UT      = 2'd2;
  localparam logic [1:0]  SEL_UP      = 2'd3;

  logic [0:0]  r_state;
  logic [1:0]  r_sel;
  logic [4:0]  r_cnt;
  logic [7:0]  r_stage [STAGE_BYTES];
  logic [15:0] r_calib [CALIB_WORDS];
  logic [7:0]  r_id;
  logic [15:0] r_ut;
  logic [23:0] r_up;
  logic        r_id_valid;
  logic        r_cal_valid;
  logic        r_ut_valid;
  logic        r_up_valid;
  logic        r_done;
  logic        r_err;

  logic [4:0]  w_last_idx;
  logic        w_take;
  logic        w_final;
  logic        w_err;

  // Index of the final byte for the frame kind being collected
  always_comb begin
    w_last_idx = 5'd0;
    case (r_sel)
      SEL_ID:  w_last_idx = 5'd0;
      SEL_CAL: w_last_idx = 5'(STAGE_BYTES - 1);
      SEL_UT:  w_last_idx = 5'd1;
      SEL_UP:  w_last_idx = 5'd2;
      default: w_last_idx = 5'd0;
    endcase
  end

  // frameStart outranks a same-cycle byte, which is then dropped
  assign w_take  = (r_state == ST_COLLECT) && received && !frameStart;
  assign w_final = w_take && (r_cnt == w_last_idx);
  assign w_err   = ((r_state == ST_IDLE) && received && !frameStart) ||
                   ((r_state == ST_COLLECT) && frameStart);

  // Frame state, latched kind and byte counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
      r_cnt   <= 5'd0;
    end else if (frameStart) begin
      r_state <= ST_COLLECT;
      r_sel   <= frameSel;
      r_cnt   <= 5'd0;
    end else if (w_final) begin
      r_state <= ST_IDLE;
      r_cnt   <= 5'd0;
    end else if (w_take) begin
      r_cnt   <= r_cnt + 5'd1;
    end else begin
      r_cnt   <= r_cnt;
    end
  end

  // Staging buffer for the bytes of the frame in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STAGE_BYTES; i++) r_stage[i] <= 8'd0;
    end else if (w_take && ({27'd0, r_cnt} < STAGE_BYTES)) begin
      r_stage[r_cnt] <= datareceive;
    end else begin
      r_stage <= r_stage;
    end
  end

  // Commit: final byte comes straight from the bus so all targets load on one edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < CALIB_WORDS; k++) r_calib[k] <= 16'd0;
      r_id        <= 8'd0;
      r_ut        <= 16'd0;
      r_up        <= 24'd0;
      r_id_valid  <= 1'b0;
      r_cal_valid <= 1'b0;
      r_ut_valid  <= 1'b0;
      r_up_valid  <= 1'b0;
    end else if (w_final) begin
      case (r_sel)
        SEL_ID: begin
          r_id       <= datareceive;
          r_id_valid <= 1'b1;
        end
        SEL_CAL: begin
          for (int k = 0; k < CALIB_WORDS - 1; k++)
            r_calib[k] <= {r_stage[2*k], r_stage[2*k+1]};
          r_calib[CALIB_WORDS-1] <= {r_stage[STAGE_BYTES-2], datareceive};
          r_cal_valid <= 1'b1;
        end
        SEL_UT: begin
          r_ut       <= {r_stage[0], datareceive};
          r_ut_valid <= 1'b1;
        end
        SEL_UP: begin
          r_up       <= {r_stage[0], r_stage[1], datareceive};
          r_up_valid <= 1'b1;
        end
        default: begin
          r_id <= r_id;
        end
      endcase
    end else begin
      r_id <= r_id;
    end
  end

  // One-cycle completion and protocol-error pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_final;
      r_err  <= w_err;
    end
  end

  // Combinational calibration read port
  always_comb begin
    rdData = 16'd0;
    if ({28'd0, rdAddr} < CALIB_WORDS) begin
      rdData = r_calib[rdAddr];
    end else begin
      rdData = 16'd0;
    end
  end

  assign id         = r_id;
  assign ut         = r_ut;
  assign up         = r_up;
  assign idValid    = r_id_valid;
  assign calibValid = r_cal_valid;
  assign utValid    = r_ut_valid;
  assign upValid    = r_up_valid;
  assign busy       = (r_state == ST_COLLECT);
  assign frameDone  = r_done;
  assign frameErr   = r_err;

endmodule
